// File: rtl/redmule_mesh_pkg.sv
// rtl/redmule_mesh_pkg.sv - mesh-wide TCDM geometry shared by tile blocks
package redmule_mesh_pkg;

    localparam int N_MEM_BANKS  = 16;
    localparam int N_WORDS_BANK = 256;

endpackage

// File: rtl/tile_tcdm_arb_pkg.sv
// rtl/tile_tcdm_arb_pkg.sv - types and widths for the tile TCDM bank arbiter
package tile_tcdm_arb_pkg;

    localparam int BANK_IDX_W  = (redmule_mesh_pkg::N_MEM_BANKS > 1) ?
                                 $clog2(redmule_mesh_pkg::N_MEM_BANKS) : 1;
    localparam int ROW_W       = $clog2(redmule_mesh_pkg::N_WORDS_BANK);
    localparam int TCDM_ADDR_W = 32;
    localparam int TCDM_DATA_W = 32;
    localparam int TCDM_BE_W   = TCDM_DATA_W / 8;

    typedef struct packed {
        logic [TCDM_ADDR_W-1:0] add;
        logic                   wen;
        logic [TCDM_BE_W-1:0]   be;
        logic [TCDM_DATA_W-1:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic                  valid;
        logic [BANK_IDX_W-1:0] bank;
        logic                  opc;
    } tcdm_rsp_pend_t;

endpackage

// File: rtl/tile_tcdm_rr_arb.sv
// rtl/tile_tcdm_rr_arb.sv - single-bank round-robin arbiter with priority pointer
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (pointer -> 0)
//   req_i         per-master request to this bank
//   gnt_o         one-hot grant (combinational)
module tile_tcdm_rr_arb #(
    parameter int N_REQ = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Scan upward from the pointer with wrap; first requester wins and the
    // pointer moves just past it so it gets lowest priority next time.
    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tile_tcdm_bank_arbiter.sv
// rtl/tile_tcdm_bank_arbiter.sv - N_REQ masters onto word-interleaved TCDM banks
// Optional feature macro: TILE_TCDM_ARB_PERF_EN (bank-conflict stall counter).
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i/add_i/wen_i/be_i/data_i master requests (wen=1 read)
//   gnt_o                         combinational grant
//   r_valid_o/r_data_o/r_opc_o    responses one cycle after grant, opc=1 out of range
//   bank_*_o, bank_rdata_i        bank macro side, read data one cycle after bank_req_o
//   conflict_cnt_o                stall counter (0 when feature disabled)
module tile_tcdm_bank_arbiter
    import tile_tcdm_arb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int N_MEM_BANKS  = redmule_mesh_pkg::N_MEM_BANKS,
    parameter int N_WORDS_BANK = redmule_mesh_pkg::N_WORDS_BANK,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    localparam int BE_W        = DATA_W / 8,
    localparam int RADDR_W     = $clog2(N_WORDS_BANK)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_REQ-1:0]                req_i,
    input  logic [N_REQ*ADDR_W-1:0]         add_i,
    input  logic [N_REQ-1:0]                wen_i,
    input  logic [N_REQ*BE_W-1:0]           be_i,
    input  logic [N_REQ*DATA_W-1:0]         data_i,
    output logic [N_REQ-1:0]                gnt_o,
    output logic [N_REQ-1:0]                r_valid_o,
    output logic [N_REQ*DATA_W-1:0]         r_data_o,
    output logic [N_REQ-1:0]                r_opc_o,
    output logic [N_MEM_BANKS-1:0]          bank_req_o,
    output logic [N_MEM_BANKS*RADDR_W-1:0]  bank_add_o,
    output logic [N_MEM_BANKS-1:0]          bank_wen_o,
    output logic [N_MEM_BANKS*BE_W-1:0]     bank_be_o,
    output logic [N_MEM_BANKS*DATA_W-1:0]   bank_wdata_o,
    input  logic [N_MEM_BANKS*DATA_W-1:0]   bank_rdata_i,
    output logic [31:0]                     conflict_cnt_o
);

    localparam logic [ADDR_W-1:0] NB_L = ADDR_W'(N_MEM_BANKS);
    localparam logic [ADDR_W-1:0] NW_L = ADDR_W'(N_WORDS_BANK);

    tcdm_req_t             mreq     [N_REQ];
    logic [N_REQ-1:0]      req_eff;
    logic [ADDR_W-1:0]     row_full [N_REQ];
    logic [BANK_IDX_W-1:0] bank_sel [N_REQ];
    logic [N_REQ-1:0]      oor;

    logic [N_REQ-1:0]      bank_req_m [N_MEM_BANKS];
    logic [N_REQ-1:0]      bank_gnt_m [N_MEM_BANKS];

    tcdm_rsp_pend_t        pend_q [N_REQ];
    tcdm_rsp_pend_t        pend_d [N_REQ];
    logic [N_REQ-1:0]      pend_rd_q, pend_rd_d;

    // Nothing is granted while reset is held.
    assign req_eff = req_i & {N_REQ{~rst_i}};

    // Decode: constant divisor, collapses to slicing for power-of-two bank counts.
    always_comb begin
        logic [ADDR_W-1:0] word;
        for (int m = 0; m < N_REQ; m++) begin
            mreq[m].add  = add_i[m*ADDR_W +: ADDR_W];
            mreq[m].wen  = wen_i[m];
            mreq[m].be   = be_i[m*BE_W +: BE_W];
            mreq[m].data = data_i[m*DATA_W +: DATA_W];
            word         = mreq[m].add >> 2;
            bank_sel[m]  = BANK_IDX_W'(word % NB_L);
            row_full[m]  = word / NB_L;
            oor[m]       = (row_full[m] >= NW_L);
        end
    end

    always_comb begin
        for (int b = 0; b < N_MEM_BANKS; b++) begin
            for (int m = 0; m < N_REQ; m++) begin
                bank_req_m[b][m] = req_eff[m] & ~oor[m] &
                                   (bank_sel[m] == BANK_IDX_W'(b));
            end
        end
    end

    for (genvar b = 0; b < N_MEM_BANKS; b++) begin : g_bank_arb
        tile_tcdm_rr_arb #(
            .N_REQ (N_REQ)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bank_req_m[b]),
            .gnt_o (bank_gnt_m[b])
        );
    end

    // Out-of-range requests bypass the banks and are granted unconditionally.
    always_comb begin
        gnt_o = '0;
        for (int m = 0; m < N_REQ; m++) begin
            if (oor[m]) begin
                gnt_o[m] = req_eff[m];
            end else begin
                for (int b = 0; b < N_MEM_BANKS; b++) begin
                    gnt_o[m] = gnt_o[m] | bank_gnt_m[b][m];
                end
            end
        end
    end

    // Request crossbar: each bank forwards its one-hot winner.
    always_comb begin
        bank_req_o   = '0;
        bank_add_o   = '0;
        bank_wen_o   = '0;
        bank_be_o    = '0;
        bank_wdata_o = '0;
        for (int b = 0; b < N_MEM_BANKS; b++) begin
            bank_req_o[b] = |bank_gnt_m[b];
            for (int m = 0; m < N_REQ; m++) begin
                if (bank_gnt_m[b][m]) begin
                    bank_add_o[b*RADDR_W +: RADDR_W] = row_full[m][RADDR_W-1:0];
                    bank_wen_o[b]                    = mreq[m].wen;
                    bank_be_o[b*BE_W +: BE_W]        = mreq[m].be;
                    bank_wdata_o[b*DATA_W +: DATA_W] = mreq[m].data;
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < N_REQ; m++) begin
            pend_d[m].valid = gnt_o[m];
            pend_d[m].bank  = bank_sel[m];
            pend_d[m].opc   = oor[m];
            pend_rd_d[m]    = gnt_o[m] & mreq[m].wen & ~oor[m];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int m = 0; m < N_REQ; m++) begin
                pend_q[m] <= '0;
            end
            pend_rd_q <= '0;
        end else begin
            for (int m = 0; m < N_REQ; m++) begin
                pend_q[m] <= pend_d[m];
            end
            pend_rd_q <= pend_rd_d;
        end
    end

    // Response crossbar; a response pending when reset rises is suppressed
    // in that same cycle, not just afterwards.
    always_comb begin
        r_valid_o = '0;
        r_opc_o   = '0;
        r_data_o  = '0;
        for (int m = 0; m < N_REQ; m++) begin
            r_valid_o[m] = pend_q[m].valid & ~rst_i;
            r_opc_o[m]   = pend_q[m].valid & ~rst_i & pend_q[m].opc;
            if (pend_q[m].valid && !rst_i && pend_rd_q[m]) begin
                r_data_o[m*DATA_W +: DATA_W] =
                    bank_rdata_i[int'(pend_q[m].bank)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef TILE_TCDM_ARB_PERF_EN
    localparam int CW = $clog2(N_REQ + 1);

    logic [31:0]   cnt_q, cnt_d;
    logic [CW-1:0] stall_n;
    logic [32:0]   cnt_sum;

    always_comb begin
        stall_n = '0;
        for (int m = 0; m < N_REQ; m++) begin
            stall_n = stall_n + CW'(req_eff[m] & ~gnt_o[m]);
        end
        cnt_sum = {1'b0, cnt_q} + 33'(stall_n);
        cnt_d   = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule
